// File: rtl/operand_sel_pkg.sv
// Shared constants and helpers for the operand select pipeline.
// Holds the immediate-extension modes and the sel-width helper.
package operand_sel_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // sel must encode every source plus the immediate slot
  function automatic int sel_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/operand_sel_pipe_if.sv
// Handshake bundle between a producer, operand_sel_pipe and its consumer.
// master drives the input fields and out_ready; slave is the pipe itself.
interface operand_sel_pipe_if
  import operand_sel_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 14,
  parameter int NUM_SRC = 4
) ();

  localparam int SEL_W = sel_w(NUM_SRC);

  logic [NUM_SRC*DATA_W-1:0] src;
  logic [IMM_W-1:0]          imm;
  logic [SEL_W-1:0]          sel;
  logic                      ext_sign;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_err;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output src, imm, sel, ext_sign, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  src, imm, sel, ext_sign, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer: output register plus skid register.
// Ports: clk, rst, in_valid_i/in_data_i/in_ready_o, out_valid_o/out_data_o/out_ready_i.
module skid_buffer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q;
  logic         in_xfer, out_xfer;

  assign in_xfer  = in_valid_i && in_ready_q;
  assign out_xfer = out_valid_q && out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_xfer || !out_valid_q) begin
      // output slot frees up: skid has priority to keep order
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      // registered ready: no path from out_ready_i
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/operand_sel_pipe.sv
// Selects one of NUM_SRC sources or the extended immediate, 1-cycle pipe.
// Ports: clk, rst, bus (slave: src/imm/sel/ext_sign/in_* in, out_* out).
module operand_sel_pipe
  import operand_sel_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 14,
  parameter int NUM_SRC = 4
) (
  input logic               clk,
  input logic               rst,
  operand_sel_pipe_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_SRC);

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_data;
  logic              op_err;
  logic [DATA_W:0]   out_pl;

  generate
    if (IMM_W == DATA_W) begin : g_imm_full
      assign imm_ext = bus.imm;
    end else begin : g_imm_ext
      logic fill;
      assign fill = (bus.ext_sign == EXT_SIGN) && bus.imm[IMM_W-1];
      assign imm_ext = {{(DATA_W-IMM_W){fill}}, bus.imm};
    end
  endgenerate

  // anything above SEL_IMM falls through as an illegal select
  always_comb begin
    op_data = '0;
    op_err  = 1'b1;
    if (bus.sel == SEL_IMM) begin
      op_data = imm_ext;
      op_err  = 1'b0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        op_data = bus.src[k*DATA_W +: DATA_W];
        op_err  = 1'b0;
      end
    end
  end

  skid_buffer #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.in_valid),
    .in_data_i  ({op_err, op_data}),
    .in_ready_o (bus.in_ready),
    .out_valid_o(bus.out_valid),
    .out_data_o (out_pl),
    .out_ready_i(bus.out_ready)
  );

  assign bus.out_err  = out_pl[DATA_W];
  assign bus.out_data = out_pl[DATA_W-1:0];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed and randomized self-checking bench for operand_sel_pipe.
// Default parameters: DATA_W=32, IMM_W=14, NUM_SRC=4.
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  operand_sel_pipe_if #(.DATA_W(32), .IMM_W(14), .NUM_SRC(4)) bus ();

  operand_sel_pipe #(
    .DATA_W (32),
    .IMM_W  (14),
    .NUM_SRC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [32:0] obs,
                     input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_op(input logic [127:0] s,
                                         input logic [13:0] im,
                                         input logic [2:0] sl,
                                         input logic es);
    logic [32:0] r;
    if (sl < 3'd4) r = {1'b0, s[32*int'(sl) +: 32]};
    else if (sl == 3'd4) r = {1'b0, {18{es & im[13]}}, im};
    else r = {1'b1, 32'h0};
    return r;
  endfunction

  logic [32:0] q[$];
  logic [32:0] held;
  logic        stall_prev;
  int          xfers;
  int          cyc;
  logic        in_x, out_x;

  initial begin
    rst           = 1'b1;
    bus.src       = '0;
    bus.imm       = '0;
    bus.sel       = '0;
    bus.ext_sign  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    step();
    chk("rst_out_valid", 33'(bus.out_valid), 33'd0);
    chk("rst_out_data", {bus.out_err, bus.out_data}, 33'd0);
    chk("rst_in_ready", 33'(bus.in_ready), 33'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 33'(bus.in_ready), 33'd1);
    chk("post_rst_out_valid", 33'(bus.out_valid), 33'd0);

    // immediate sign/zero extension
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd4;
    bus.imm       = 14'h2001;
    bus.ext_sign  = 1'b1;
    step();
    chk("imm_sext_valid", 33'(bus.out_valid), 33'd1);
    chk("imm_sext", {bus.out_err, bus.out_data}, {1'b0, 32'hFFFFE001});
    bus.ext_sign = 1'b0;
    step();
    chk("imm_zext", {bus.out_err, bus.out_data}, {1'b0, 32'h00002001});
    bus.in_valid = 1'b0;
    step();
    chk("imm_drained", 33'(bus.out_valid), 33'd0);

    // register source and illegal select
    bus.src[64 +: 32] = 32'hDEADBEEF;
    bus.sel           = 3'd2;
    bus.in_valid      = 1'b1;
    step();
    chk("src2", {bus.out_err, bus.out_data}, {1'b0, 32'hDEADBEEF});
    bus.sel = 3'd5;
    step();
    chk("illegal_sel", {bus.out_err, bus.out_data}, {1'b1, 32'h0});
    bus.in_valid = 1'b0;
    step();
    chk("illegal_drained", 33'(bus.out_valid), 33'd0);

    // stall: two accepted, third refused
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.sel          = 3'd0;
    bus.src[0 +: 32] = 32'hA1;
    step();
    chk("stall_first", {bus.out_err, bus.out_data}, 33'hA1);
    chk("stall_rdy1", 33'(bus.in_ready), 33'd1);
    bus.src[0 +: 32] = 32'hA2;
    step();
    chk("stall_rdy_drop", 33'(bus.in_ready), 33'd0);
    chk("stall_hold1", {bus.out_err, bus.out_data}, 33'hA1);
    bus.src[0 +: 32] = 32'hA3;
    step();
    chk("stall_rdy_still0", 33'(bus.in_ready), 33'd0);
    chk("stall_hold2", {bus.out_err, bus.out_data}, 33'hA1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("drain_second", {bus.out_err, bus.out_data}, 33'hA2);
    chk("drain_rdy_back", 33'(bus.in_ready), 33'd1);
    step();
    chk("drain_empty", 33'(bus.out_valid), 33'd0);

    // full-throughput streaming
    for (int j = 0; j < 4; j++) bus.src[32*j +: 32] = 32'h1000_0000 + j;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.sel = 3'(k % 4);
      step();
      chk("stream_valid", 33'(bus.out_valid), 33'd1);
      chk("stream_data", {bus.out_err, bus.out_data},
          {1'b0, 32'h1000_0000 + 32'(k % 4)});
      chk("stream_rdy", 33'(bus.in_ready), 33'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_done", 33'(bus.out_valid), 33'd0);

    // reset with both entries full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd1;
    step();
    step();
    chk("full_before_rst", 33'(bus.in_ready), 33'd0);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();
    chk("rst_full_valid", 33'(bus.out_valid), 33'd0);
    chk("rst_full_data", {bus.out_err, bus.out_data}, 33'd0);
    chk("rst_full_rdy", 33'(bus.in_ready), 33'd0);
    rst = 1'b0;
    step();
    chk("rst_rel_rdy", 33'(bus.in_ready), 33'd1);
    chk("rst_rel_valid", 33'(bus.out_valid), 33'd0);
    bus.out_ready = 1'b1;
    step();
    chk("no_stale", 33'(bus.out_valid), 33'd0);

    // random traffic against a queue model
    xfers      = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    held       = '0;
    while (xfers < 10000 && cyc < 60000) begin
      if (stall_prev) begin
        chk("rnd_stall_valid", 33'(bus.out_valid), 33'd1);
        chk("rnd_stall_data", {bus.out_err, bus.out_data}, held);
      end
      chk("rnd_valid_occ", 33'(bus.out_valid), 33'(q.size() > 0));
      chk("rnd_ready_occ", 33'(bus.in_ready), 33'(q.size() < 2));
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.src       = {$urandom, $urandom, $urandom, $urandom};
      bus.imm       = 14'($urandom);
      bus.sel       = 3'($urandom_range(0, 7));
      bus.ext_sign  = 1'($urandom);
      #1;
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      if (out_x) begin
        if (q.size() == 0) chk("rnd_underflow", 33'd1, 33'd0);
        else chk("rnd_order", {bus.out_err, bus.out_data}, q.pop_front());
        xfers++;
      end
      if (in_x) q.push_back(ref_op(bus.src, bus.imm, bus.sel, bus.ext_sign));
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_err, bus.out_data};
      step();
      cyc++;
    end
    if (xfers < 10000) chk("rnd_timeout", 33'(xfers), 33'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter IMM_W, default 14, immediate width; IMM_W <= DATA_W.
REQ-003 SHALL have parameter NUM_SRC, default 4, number of register-source inputs, >= 2.
REQ-004 SHALL have localparam SEL_W = clog2(NUM_SRC+1).
REQ-005 One clock; reset is synchronous and active-high. Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: src  input  NUM_SRC*DATA_W  packed sources; src[k] occupies bits k*DATA_W +: DATA_W.
REQ-008 Port: imm  input  IMM_W  immediate operand.
REQ-009 Port: sel  input  SEL_W  source select: 0..NUM_SRC-1 = src[sel], NUM_SRC = extended imm, larger = illegal.
REQ-010 Port: ext_sign  input  1  1 = sign-extend imm, 0 = zero-extend imm.
REQ-011 Port: in_valid  input  1  src/imm/sel/ext_sign valid this cycle.
REQ-012 Port: in_ready  output  1  block accepts input this cycle.
REQ-013 Port: out_data  output  DATA_W  selected operand.
REQ-014 Port: out_err  output  1  selected operand came from an illegal sel.
REQ-015 Port: out_valid  output  1  out_data/out_err valid.
REQ-016 Port: out_ready  input  1  consumer accepts output this cycle.

Function
REQ-017 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-018 Selection/extension SHALL be computed combinationally from the input fields and captured only on an input transfer.
REQ-019 Immediate extension SHALL fill bits DATA_W-1..IMM_W with imm[IMM_W-1] when ext_sign=1, with 0 otherwise; IMM_W == DATA_W passes imm unchanged.
REQ-020 Illegal sel SHALL produce out_data = 0 and out_err = 1; legal sel SHALL produce out_err = 0.
REQ-021 Latency SHALL be exactly 1 cycle: a transfer accepted at edge N with empty storage is presented on out_valid/out_data after edge N.
REQ-022 Storage SHALL be two entries (output register + skid register); throughput one transfer per cycle while out_ready=1.
REQ-023 in_ready SHALL be a register output, equal to 1 exactly when the skid entry is empty; no combinational path from out_ready to in_ready.
REQ-024 Output stalled (out_valid=1, out_ready=0) while input transfers: entry SHALL go to skid register; in_ready SHALL drop after that edge.
REQ-025 Output transfer with skid full: skid entry SHALL move to output register on the same edge; in_ready SHALL return to 1.
REQ-026 Simultaneous input and output transfer with skid empty: new entry SHALL replace output register; out_valid stays 1.
REQ-027 out_data/out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 Entries SHALL leave in acceptance order; none dropped or duplicated.
REQ-029 Input fields SHALL be ignored when in_valid=0.

Reset
REQ-030 While rst=1 at a rising edge: out_valid=0, out_data=0, out_err=0, skid empty, in_ready=0.
REQ-031 First edge with rst=0 SHALL set in_ready=1; in-flight entries at reset are discarded.

Structure
REQ-032 Package operand_sel_pkg SHALL hold the ext-mode constants (EXT_ZERO=0, EXT_SIGN=1) and an sel-width helper function.
REQ-033 Two-entry storage SHALL be a sub-module skid_buffer, parametrised by payload width (DATA_W+1); select/extend logic stays in operand_sel_pipe.

Verification (DATA_W=32, IMM_W=14, NUM_SRC=4)
REQ-034 sel=4, imm=14'h2001, ext_sign=1 then 0, out_ready=1 -> out_data 32'hFFFFE001 then 32'h00002001, each 1 cycle after accept, out_err=0.
REQ-035 src[2]=32'hDEADBEEF, sel=2; sel=5 -> 32'hDEADBEEF out_err=0; then 32'h0 out_err=1.
REQ-036 out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 on third; release out_ready -> outputs in order, in_ready=1 after first drain.
REQ-037 Continuous in_valid=1, out_ready=1 for 16 cycles, sel cycling 0..3 -> 16 outputs, one per cycle, in order.
REQ-038 rst=1 for one cycle with both entries full -> out_valid=0, out_data=0, in_ready=0; next cycle in_ready=1, no stale output.
REQ-039 Random in_valid/out_ready toggling, 10k transfers -> scoreboard matches, out_data stable during every stall.
